regfile_ng: RTL and testbench

Parametrised register file for the MIPS32 datapath: two asynchronous read ports, one synchronous write port, register 0 hardwired to zero, and optional write-to-read bypass. After reset a sequential clear engine zeroes every register, one per cycle, and signals `ready` when the file is usable. It replaces the fixed 32×32 file in the decode stage.

---
 rtl/regfile_ng.sv | 95 +++++++++
 tb/tb_regfile_ng.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ng.sv
// Register file with two combinational read ports, one synchronous write port,
// optional hardwired zero register and write-to-read forwarding, cleared sequentially after reset.
module regfile_ng #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  input  logic [ADDR_W-1:0] Rw,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] Da,
  output logic [DATA_W-1:0] Db,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              ready_nxt;
  logic              wr_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  // A write is real only in RUN and when it does not target the hardwired zero register.
  assign wr_ok = we && (state == RUN) && !((ZERO_REG != 0) && (Rw == '0));

  function automatic logic [DATA_W-1:0] read_port(
    input logic              rdy,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] mem_q,
    input logic              wr,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (!rdy)
      return '0;
    else if ((ZERO_REG != 0) && (addr == '0))
      return '0;
    else if ((BYPASS != 0) && wr && (waddr == addr))
      return wdata;
    else
      return mem_q;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_nxt = ready;
    case (state)
      CLEAR: begin
        if (cnt == LAST) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      RUN: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ready <= ready_nxt;
    end
  end

  // The array is left untouched on the reset edge; the clear engine zeroes it afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[cnt] <= '0;
      else if (wr_ok)
        mem[Rw] <= din;
    end
  end

  assign Da = read_port(ready, Ra, mem[Ra], wr_ok, Rw, din);
  assign Db = read_port(ready, Rb, mem[Rb], wr_ok, Rw, din);

endmodule

// File: tb/tb_regfile_ng.sv
// Directed bench for regfile_ng: default, no-zero/no-bypass and narrow (16x8) instances
// checked against a queue of expected values pushed as stimulus is applied.
module tb_regfile_ng;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra, rb, rw;
  logic        we;
  logic [31:0] din;
  logic [31:0] da0, db0, da1, db1;
  logic        rdy0, rdy1;
  logic [2:0]  ra2, rb2, rw2;
  logic        we2;
  logic [15:0] din2, da2, db2;
  logic        rdy2;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  regfile_ng #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u0 (
    .clk(clk), .rst(rst), .Ra(ra), .Rb(rb), .Rw(rw), .we(we), .din(din),
    .Da(da0), .Db(db0), .ready(rdy0));

  regfile_ng #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .Ra(ra), .Rb(rb), .Rw(rw), .we(we), .din(din),
    .Da(da1), .Db(db1), .ready(rdy1));

  regfile_ng #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u2 (
    .clk(clk), .rst(rst), .Ra(ra2), .Rb(rb2), .Rw(rw2), .we(we2), .din(din2),
    .Da(da2), .Db(db2), .ready(rdy2));

  task automatic push_exp(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check_pop(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rw  = a;
    din = d;
    we  = 1'b1;
    tick();
    we  = 1'b0;
  endtask

  // Counts clock edges until each instance raises ready; 0 means it never did within the budget.
  task automatic wait_ready(input bit scribble, output int n0, output int n1, output int n2);
    n0 = 0; n1 = 0; n2 = 0;
    for (int c = 1; c <= 64; c++) begin
      if (scribble) begin
        we  = 1'b1;
        din = 32'hDEAD_BEEF;
        rw  = 5'(31 - (c % 32));
      end
      tick();
      if (rdy0 && n0 == 0) n0 = c;
      if (rdy1 && n1 == 0) n1 = c;
      if (rdy2 && n2 == 0) n2 = c;
      if (n0 != 0 && n1 != 0 && n2 != 0) break;
    end
    we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, n1, n2;
    rst = 1'b1; we = 1'b0; ra = '0; rb = '0; rw = '0; din = '0;
    we2 = 1'b0; ra2 = '0; rb2 = '0; rw2 = '0; din2 = '0;

    // Reset state
    tick(); tick();
    ra = 5'd3;
    push_exp(32'd0); push_exp(32'd0); push_exp(32'd0); push_exp(32'd0);
    settle();
    check_pop("rst_ready0", {31'd0, rdy0});
    check_pop("rst_ready1", {31'd0, rdy1});
    check_pop("rst_ready2", {31'd0, rdy2});
    check_pop("rst_da0", da0);

    // Initial clear latency
    rst = 1'b0;
    wait_ready(1'b0, n0, n1, n2);
    push_exp(32'd32); push_exp(32'd32); push_exp(32'd8);
    check_pop("clear_lat0", n0);
    check_pop("clear_lat1", n1);
    check_pop("clear_lat2", n2);

    // Preload garbage
    for (int a = 0; a < 32; a++) wr(5'(a), 32'hA500_0000 | a);
    ra = 5'd3; rb = 5'd0;
    push_exp(32'hA500_0003); push_exp(32'hA500_0003); push_exp(32'd0); push_exp(32'hA500_0000);
    settle();
    check_pop("preload_da0", da0);
    check_pop("preload_da1", da1);
    check_pop("preload_r0_db0", db0);
    check_pop("preload_r0_db1", db1);

    // One-cycle reset pulse; reads forced to 0, writes during clear ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ra = 5'd3;
    push_exp(32'd0); push_exp(32'd0); push_exp(32'd0);
    settle();
    check_pop("clear_da0", da0);
    check_pop("clear_da1", da1);
    check_pop("clear_ready0", {31'd0, rdy0});
    wait_ready(1'b1, n0, n1, n2);
    push_exp(32'd32); push_exp(32'd32); push_exp(32'd8);
    check_pop("pulse_lat0", n0);
    check_pop("pulse_lat1", n1);
    check_pop("pulse_lat2", n2);

    for (int a = 0; a < 32; a++) begin
      ra = 5'(a); rb = 5'(31 - a);
      push_exp(32'd0); push_exp(32'd0); push_exp(32'd0);
      settle();
      check_pop($sformatf("zero_da0_r%0d", a), da0);
      check_pop($sformatf("zero_db0_r%0d", 31 - a), db0);
      check_pop($sformatf("zero_da1_r%0d", a), da1);
    end

    // Basic write/read
    wr(5'd5, 32'h1234_5678);
    ra = 5'd5; rb = 5'd5;
    push_exp(32'h1234_5678); push_exp(32'h1234_5678); push_exp(32'h1234_5678); push_exp(32'h1234_5678);
    settle();
    check_pop("wr_r5_da0", da0);
    check_pop("wr_r5_db0", db0);
    check_pop("wr_r5_da1", da1);
    check_pop("wr_r5_db1", db1);

    // Zero register
    we = 1'b1; rw = 5'd0; din = 32'hFFFF_FFFF; ra = 5'd0;
    push_exp(32'd0); push_exp(32'd0);
    settle();
    check_pop("r0_same_da0", da0);
    check_pop("r0_same_da1", da1);
    tick();
    we = 1'b0;
    push_exp(32'd0); push_exp(32'hFFFF_FFFF);
    settle();
    check_pop("r0_next_da0", da0);
    check_pop("r0_next_da1", da1);

    // Bypass
    wr(5'd7, 32'h0000_0001);
    we = 1'b1; rw = 5'd7; din = 32'hA5A5_A5A5; ra = 5'd7; rb = 5'd7;
    push_exp(32'hA5A5_A5A5); push_exp(32'hA5A5_A5A5); push_exp(32'h0000_0001); push_exp(32'h0000_0001);
    settle();
    check_pop("byp_same_da0", da0);
    check_pop("byp_same_db0", db0);
    check_pop("byp_same_da1", da1);
    check_pop("byp_same_db1", db1);
    tick();
    we = 1'b0;
    push_exp(32'hA5A5_A5A5); push_exp(32'hA5A5_A5A5);
    settle();
    check_pop("byp_next_da0", da0);
    check_pop("byp_next_da1", da1);

    // Reset mid-clear restarts from address 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_exp(32'd0);
    settle();
    check_pop("midclr_ready0", {31'd0, rdy0});
    wait_ready(1'b0, n0, n1, n2);
    push_exp(32'd32); push_exp(32'd32); push_exp(32'd8);
    check_pop("midclr_lat0", n0);
    check_pop("midclr_lat1", n1);
    check_pop("midclr_lat2", n2);

    // Narrow instance: 16-bit data, 8 registers
    ra2 = 3'd3;
    push_exp(32'd0);
    settle();
    check_pop("n_clear_da2", {16'd0, da2});
    we2 = 1'b1; rw2 = 3'd7; din2 = 16'hBEEF; ra2 = 3'd7;
    push_exp(32'h0000_BEEF);
    settle();
    check_pop("n_byp_da2", {16'd0, da2});
    tick();
    we2 = 1'b0; rb2 = 3'd7;
    push_exp(32'h0000_BEEF); push_exp(32'h0000_BEEF);
    settle();
    check_pop("n_r7_da2", {16'd0, da2});
    check_pop("n_r7_db2", {16'd0, db2});
    we2 = 1'b1; rw2 = 3'd0; din2 = 16'h1234;
    tick();
    we2 = 1'b0; ra2 = 3'd0;
    push_exp(32'd0);
    settle();
    check_pop("n_r0_da2", {16'd0, da2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
